// File: rtl/otp_program_sequencer.sv
// One-word OTP fuse programming sequencer: lifecycle/lock gating, blank check,
// timed program pulse and readback verify. All outputs are registered.
module otp_program_sequencer #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PGM_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              lifecycle_allows,
  input  logic [3:0]        part_lock,
  output logic              rsp_valid,
  output logic [2:0]        rsp_status,
  output logic              busy,
  output logic [ADDR_W-1:0] fuse_addr,
  output logic [DATA_W-1:0] fuse_wdata,
  output logic              fuse_pgm_en,
  output logic              fuse_rd_en,
  input  logic [DATA_W-1:0] fuse_rdata,
  input  logic              fuse_rd_valid
);

  localparam int unsigned CNT_W = (PGM_CYCLES > 1) ? $clog2(PGM_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BLANK_RD,
    S_BLANK_WAIT,
    S_PROGRAM,
    S_VERIFY_RD,
    S_VERIFY_WAIT,
    S_RESP
  } state_e;

  typedef enum logic [2:0] {
    ST_OK           = 3'd0,
    ST_DENIED_LC    = 3'd1,
    ST_DENIED_LOCK  = 3'd2,
    ST_ALREADY_PROG = 3'd3,
    ST_VERIFY_FAIL  = 3'd4,
    ST_ABORTED      = 3'd5
  } status_e;

  state_e              state_q, state_d;
  status_e             status_q, status_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_en_q, rd_en_d;
  logic                pgm_en_q, pgm_en_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic [1:0]          part_sel;

  assign part_sel = req_addr[ADDR_W-1 -: 2];

  // Strobes are computed for the *next* state so that the registered outputs
  // line up exactly with the cycles spent in BLANK_RD/PROGRAM/VERIFY_RD/RESP.
  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_en_d     = 1'b0;
    pgm_en_d    = 1'b0;
    rsp_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (!lifecycle_allows) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            status_d    = ST_DENIED_LC;
          end else if (part_lock[part_sel]) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            status_d    = ST_DENIED_LOCK;
          end else if (req_wdata == '0) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            status_d    = ST_OK;
          end else begin
            state_d = S_BLANK_RD;
            rd_en_d = 1'b1;
          end
        end
      end

      S_BLANK_RD: state_d = S_BLANK_WAIT;

      S_BLANK_WAIT: begin
        if (fuse_rd_valid) begin
          if (fuse_rdata != '0) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            status_d    = ST_ALREADY_PROG;
          end else begin
            state_d  = S_PROGRAM;
            cnt_d    = CNT_W'(PGM_CYCLES - 1);
            pgm_en_d = 1'b1;
          end
        end
      end

      S_PROGRAM: begin
        if (!lifecycle_allows) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          status_d    = ST_ABORTED;
        end else if (cnt_q == '0) begin
          state_d = S_VERIFY_RD;
          rd_en_d = 1'b1;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          pgm_en_d = 1'b1;
        end
      end

      S_VERIFY_RD: state_d = S_VERIFY_WAIT;

      S_VERIFY_WAIT: begin
        if (fuse_rd_valid) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          status_d    = (fuse_rdata == wdata_q) ? ST_OK : ST_VERIFY_FAIL;
        end
      end

      S_RESP: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      status_q    <= ST_OK;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_en_q     <= 1'b0;
      pgm_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_en_q     <= rd_en_d;
      pgm_en_q    <= pgm_en_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign req_ready   = ready_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_status  = status_q;
  assign fuse_addr   = addr_q;
  assign fuse_wdata  = wdata_q;
  assign fuse_pgm_en = pgm_en_q;
  assign fuse_rd_en  = rd_en_q;

  a_no_rd_pgm_overlap: assert property (@(posedge clk) disable iff (rst)
    !(rd_en_q && pgm_en_q));

  a_pgm_only_in_program: assert property (@(posedge clk) disable iff (rst)
    pgm_en_q |-> (state_q == S_PROGRAM));

endmodule

// File: doc/otp_program_sequencer.md
Name: otp_program_sequencer

Overview:
- Sequences one-word programming operations into the OTP fuse macro: lifecycle and partition-lock gating, blank check, timed program pulse, readback verify.
- Sits between the security register bus (single requester) and the fuse macro.
- Guarantees the fuse-protection invariants by construction: no reprogramming, no programming outside permitted lifecycle, no fuse activity without an accepted request.

Parameters:
ADDR_W, 6, fuse word address width; top 2 bits select the partition (4 partitions).
DATA_W, 32, fuse word width.
PGM_CYCLES, 16, program pulse length in clk cycles (>=1).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  program request valid
req_ready  out  1  sequencer can accept a request
req_addr  in  ADDR_W  target fuse word
req_wdata  in  DATA_W  value to program
lifecycle_allows  in  1  lifecycle state permits programming
part_lock  in  4  per-partition program lock; bit i locks partition i
rsp_valid  out  1  one-cycle completion pulse
rsp_status  out  3  0 OK, 1 DENIED_LC, 2 DENIED_LOCK, 3 ALREADY_PROG, 4 VERIFY_FAIL, 5 ABORTED
busy  out  1  operation in flight
fuse_addr  out  ADDR_W  macro address
fuse_wdata  out  DATA_W  macro program data
fuse_pgm_en  out  1  program strobe
fuse_rd_en  out  1  one-cycle read request
fuse_rdata  in  DATA_W  macro read data
fuse_rd_valid  in  1  fuse_rdata valid

Behaviour:
- Reset values: FSM in IDLE; req_ready=1; all other outputs 0, including addr, wdata, and status. Reset during any state returns to IDLE at that edge. fuse_pgm_en is 0 from the edge at which rst is sampled. No rsp is emitted for the aborted operation.
- States: IDLE, BLANK_RD, BLANK_WAIT, PROGRAM, VERIFY_RD, VERIFY_WAIT, RESP.
- IDLE: req_ready=1. Acceptance is req_valid && req_ready. On acceptance, latch addr and wdata into fuse_addr and fuse_wdata. These outputs hold until the next acceptance.
- Gating on acceptance, checked in priority order:
  - !lifecycle_allows -> RESP with DENIED_LC.
  - else part_lock[req_addr[ADDR_W-1 -: 2]] -> RESP with DENIED_LOCK.
  - else req_wdata==0 -> RESP with OK; no macro access.
  - else -> BLANK_RD.
- BLANK_RD: fuse_rd_en=1 for exactly one cycle, then go to BLANK_WAIT.
- BLANK_WAIT: hold until fuse_rd_valid. If fuse_rdata != 0 -> RESP with ALREADY_PROG. Otherwise -> PROGRAM, with counter loaded to PGM_CYCLES-1.
- PROGRAM: fuse_pgm_en=1 in every cycle spent in the state, which is exactly PGM_CYCLES consecutive cycles; addr and wdata stable throughout.
  - Counter decrements each cycle; at 0 go to VERIFY_RD.
  - If lifecycle_allows is sampled low in any PROGRAM cycle, fuse_pgm_en is 0 on the following cycle and the FSM goes to RESP with ABORTED.
- VERIFY_RD / VERIFY_WAIT: read handshake identical to BLANK_RD / BLANK_WAIT. fuse_rdata == latched wdata -> OK; otherwise VERIFY_FAIL.
- RESP: rsp_valid=1 for one cycle with rsp_status; return to IDLE. rsp_status holds its value until the next RESP.
- busy=1 in every state except IDLE; req_ready = !busy.
- Handshake rules:
  - req_valid while not ready is ignored; no queueing.
  - fuse_rd_valid outside the *_WAIT states is ignored.
  - fuse_rd_en and fuse_pgm_en are never high simultaneously.
- Latency:
  - Gated-reject request: rsp 1 cycle after acceptance.
  - Full success: 1 + (blank read latency) + PGM_CYCLES + 1 + (verify read latency) + 1 cycles.
- part_lock and lifecycle_allows are sampled only at acceptance, except the lifecycle abort check in PROGRAM.

Test Plan:
- lifecycle_allows=1, part_lock=0, addr=0x05, wdata=0xA5A5_0001, blank read 0 (1-cycle latency), verify read 0xA5A5_0001 -> fuse_pgm_en high exactly 16 cycles; rsp OK.
- lifecycle_allows=0, any request -> rsp DENIED_LC 1 cycle after acceptance; fuse_rd_en and fuse_pgm_en never asserted.
- part_lock=4'b0100, addr=0x25 (partition 2) -> DENIED_LOCK; same request to addr=0x05 proceeds to BLANK_RD.
- Blank read returns 0x0000_0010 -> rsp ALREADY_PROG; no program pulse.
- lifecycle_allows dropped in the 5th PROGRAM cycle -> fuse_pgm_en low the next cycle; rsp ABORTED; no verify read.
- Verify read returns 0xA5A5_0000 for wdata 0xA5A5_0001 -> VERIFY_FAIL. Separately, rst asserted mid-PROGRAM -> fuse_pgm_en 0 at that edge, req_ready=1, no rsp_valid.
